cory_rr_sel8: RTL and testbench

Round-robin select generator for an 8-way merge. It watches the valid lines of eight sources and drives the select stream (`o_s_v`/`o_s_d`/`i_s_r`) of the downstream 8:1 valid/ready mux. Each accepted select forwards exactly one beat from one source. A grant is held for up to BURST beats, then rotates so every source is served fairly. It sits directly upstream of the mux's select port; the eight source valids are tapped in parallel with the mux data inputs.

---
 rtl/cory_rr_pick8.sv | 26 ++
 rtl/cory_rr_sel8.sv | 91 +++++++++
 tb/tb_cory_rr_sel8.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cory_rr_pick8.sv
// Rotate-priority search over eight request lines: returns the first set bit
// found scanning start, start+1, ... start+7 (mod 8).
module cory_rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] start,
  output logic       found,
  output logic [2:0] idx
);

  logic [2:0] w_pos;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = start;
    w_pos = start;
    for (int i = 7; i >= 0; i--) begin
      w_pos = start + 3'(i);
      if (req[w_pos]) begin
        found = 1'b1;
        idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/cory_rr_sel8.sv
// Round-robin select generator for an 8:1 valid/ready mux; a grant holds for
// up to BURST beats, or until its source goes idle, then rotates.
`ifndef CORY_RR_SEL8_SV
`define CORY_RR_SEL8_SV

module cory_rr_sel8 #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_req,
  output logic       o_s_v,
  output logic [2:0] o_s_d,
  input  logic       i_s_r
);

  localparam int unsigned CntW = $clog2(BURST + 1);

  logic            r_act;
  logic [2:0]      r_sel;
  logic [2:0]      r_ptr;
  logic [CntW-1:0] r_cnt;

  logic            w_act_d;
  logic [2:0]      w_sel_d;
  logic [2:0]      w_ptr_d;
  logic [CntW-1:0] w_cnt_d;

  logic            w_hs;
  logic            w_last;
  logic            w_rel;
  logic            w_arb;
  logic            w_found;
  logic [2:0]      w_idx;

  cory_rr_pick8 u_pick (
    .req   (i_req),
    .start (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  // Never offer a select for an empty source: the mux accepts regardless.
  always_comb begin
    o_s_v = r_act & i_req[r_sel];
    o_s_d = r_sel;
  end

  always_comb begin
    w_hs   = o_s_v & i_s_r;
    w_last = (r_cnt == CntW'(BURST - 1));
    w_rel  = (w_hs & w_last) | (r_act & ~i_req[r_sel]);
    w_arb  = ~r_act | w_rel;
  end

  always_comb begin
    w_act_d = r_act;
    w_sel_d = r_sel;
    w_ptr_d = r_ptr;
    w_cnt_d = r_cnt;
    if (w_arb) begin
      if (w_found) begin
        w_act_d = 1'b1;
        w_sel_d = w_idx;
        w_ptr_d = w_idx + 3'd1;
        w_cnt_d = '0;
      end else begin
        w_act_d = 1'b0;
      end
    end else if (w_hs) begin
      w_cnt_d = r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act <= 1'b0;
      r_sel <= 3'd0;
      r_ptr <= 3'd0;
      r_cnt <= '0;
    end else begin
      r_act <= w_act_d;
      r_sel <= w_sel_d;
      r_ptr <= w_ptr_d;
      r_cnt <= w_cnt_d;
    end
  end

endmodule

`endif

// File: tb/tb_cory_rr_sel8.sv
// Directed bench for cory_rr_sel8 with a BURST=4 and a BURST=1 instance.
module tb_cory_rr_sel8;

  logic       clk;
  logic       reset_n;
  logic [7:0] req4, req1;
  logic       sr4, sr1;
  logic       sv4, sv1;
  logic [2:0] sd4, sd1;

  int total;
  int bad;

  cory_rr_sel8 #(.BURST(4)) u_dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (req4),
    .o_s_v   (sv4),
    .o_s_d   (sd4),
    .i_s_r   (sr4)
  );

  cory_rr_sel8 #(.BURST(1)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (req1),
    .o_s_v   (sv1),
    .o_s_d   (sd1),
    .i_s_r   (sr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req4 = 8'h00;
    req1 = 8'h00;
    sr4  = 1'b0;
    sr1  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (sv4 !== 1'b0 || sd4 !== 3'd0) begin
      bad++;
      $display("FAIL reset_b4: v=%b d=%0d want v=0 d=0", sv4, sd4);
    end
    total++;
    if (sv1 !== 1'b0 || sd1 !== 3'd0) begin
      bad++;
      $display("FAIL reset_b1: v=%b d=%0d want v=0 d=0", sv1, sd1);
    end
    tick();
    total++;
    if (sv4 !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_req: v=%b want 0", sv4);
    end
  endtask

  task automatic test_single_src();
    do_reset();
    req4 = 8'h04;
    sr4  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (sv4 !== 1'b1 || sd4 !== 3'd2) begin
        bad++;
        $display("FAIL single_src cyc%0d: v=%b d=%0d want v=1 d=2", k, sv4, sd4);
      end
    end
  endtask

  task automatic test_two_src();
    logic [2:0] exp;
    do_reset();
    req4 = 8'h81;
    sr4  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      exp = ((k / 4) % 2 == 1) ? 3'd7 : 3'd0;
      total++;
      if (sv4 !== 1'b1 || sd4 !== exp) begin
        bad++;
        $display("FAIL two_src cyc%0d: v=%b d=%0d want v=1 d=%0d", k, sv4, sd4, exp);
      end
    end
  endtask

  task automatic test_burst1_wrap();
    logic [2:0] exp;
    do_reset();
    req1 = 8'hFF;
    sr1  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp = 3'(k % 8);
      total++;
      if (sv1 !== 1'b1 || sd1 !== exp) begin
        bad++;
        $display("FAIL burst1 cyc%0d: v=%b d=%0d want v=1 d=%0d", k, sv1, sd1, exp);
      end
    end
  endtask

  task automatic test_hold();
    logic [2:0] exp [4];
    exp = '{3'd3, 3'd3, 3'd3, 3'd5};
    do_reset();
    req4 = 8'h08;
    sr4  = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) req4 = 8'h28;
      tick();
      total++;
      if (sv4 !== 1'b1 || sd4 !== 3'd3) begin
        bad++;
        $display("FAIL hold cyc%0d: v=%b d=%0d want v=1 d=3", k, sv4, sd4);
      end
    end
    // Full four-beat burst must still be owed after the stall.
    sr4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (sv4 !== 1'b1 || sd4 !== exp[k]) begin
        bad++;
        $display("FAIL hold_release cyc%0d: v=%b d=%0d want v=1 d=%0d", k, sv4, sd4, exp[k]);
      end
    end
  endtask

  task automatic test_idle_release();
    do_reset();
    req4 = 8'h02;
    sr4  = 1'b0;
    tick();
    total++;
    if (sv4 !== 1'b1 || sd4 !== 3'd1) begin
      bad++;
      $display("FAIL idle_grant: v=%b d=%0d want v=1 d=1", sv4, sd4);
    end
    req4 = 8'h40;
    #1;
    total++;
    if (sv4 !== 1'b0) begin
      bad++;
      $display("FAIL idle_qualify: v=%b want 0", sv4);
    end
    tick();
    total++;
    if (sv4 !== 1'b1 || sd4 !== 3'd6) begin
      bad++;
      $display("FAIL idle_regrant: v=%b d=%0d want v=1 d=6", sv4, sd4);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] exp [4];
    exp = '{3'd0, 3'd0, 3'd0, 3'd1};
    do_reset();
    req4 = 8'h01;
    sr4  = 1'b1;
    tick();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (sv4 !== 1'b0 || sd4 !== 3'd0) begin
      bad++;
      $display("FAIL async_reset: v=%b d=%0d want v=0 d=0", sv4, sd4);
    end
    tick();
    reset_n = 1'b1;
    tick();
    total++;
    if (sv4 !== 1'b1 || sd4 !== 3'd0) begin
      bad++;
      $display("FAIL async_first: v=%b d=%0d want v=1 d=0", sv4, sd4);
    end
    // A fresh count of four beats proves no carry-over from before reset.
    req4 = 8'h03;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (sv4 !== 1'b1 || sd4 !== exp[k]) begin
        bad++;
        $display("FAIL async_count cyc%0d: v=%b d=%0d want v=1 d=%0d", k, sv4, sd4, exp[k]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_src();
    test_two_src();
    test_burst1_wrap();
    test_hold();
    test_idle_release();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
